// File: rtl/setpoint_encoder_if.sv
// Setpoint control/status bundle between the button/keypad front end and the encoder.
// The master drives the adjust requests; the slave (encoder) returns setpoint, code and status.
interface setpoint_encoder_if;
  logic       up;
  logic       down;
  logic       load;
  logic [7:0] load_bcd;
  logic [7:0] set_bcd;
  logic [7:0] code;
  logic       valid;
  logic       err;

  modport master (
    output up, down, load, load_bcd,
    input  set_bcd, code, valid, err
  );

  modport slave (
    input  up, down, load, load_bcd,
    output set_bcd, code, valid, err
  );
endinterface

// File: rtl/setpoint_encoder.sv
// Two-digit BCD setpoint register with a sequential BCD-to-ADC-code converter:
// code = OFFSET + 10*tens + ones, built by repeated addition of 10 once per tens digit.
module setpoint_encoder #(
  parameter logic [7:0] OFFSET      = 8'h38,
  parameter logic [7:0] DEFAULT_SET = 8'h23
) (
  input  logic               clk,
  input  logic               rst,
  setpoint_encoder_if.slave  sp_if
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [7:0] DEFAULT_CODE =
    OFFSET + 8'd10 * {4'd0, DEFAULT_SET[7:4]} + {4'd0, DEFAULT_SET[3:0]};

  state_t     state_q;
  logic [7:0] set_q, set_d;
  logic [7:0] code_q;
  logic [7:0] acc_q;
  logic [3:0] cnt_q;
  logic       valid_q;
  logic       err_q, err_d;
  logic       change_d;

  logic [3:0] tens, ones;
  logic       load_ok;

  assign tens    = set_q[7:4];
  assign ones    = set_q[3:0];
  assign load_ok = (sp_if.load_bcd[7:4] <= 4'd9) && (sp_if.load_bcd[3:0] <= 4'd9);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    set_d    = set_q;
    change_d = 1'b0;
    err_d    = 1'b0;
    if (sp_if.load) begin
      if (load_ok) begin
        set_d    = sp_if.load_bcd;
        change_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (sp_if.up && !sp_if.down) begin
      if (set_q != 8'h99) begin
        change_d = 1'b1;
        set_d    = (ones == 4'd9) ? {tens + 4'd1, 4'd0} : {tens, ones + 4'd1};
      end
    end else if (sp_if.down && !sp_if.up) begin
      if (set_q != 8'h00) begin
        change_d = 1'b1;
        set_d    = (ones == 4'd0) ? {tens - 4'd1, 4'd9} : {tens, ones - 4'd1};
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      set_q   <= DEFAULT_SET;
      code_q  <= DEFAULT_CODE;
      acc_q   <= DEFAULT_CODE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      set_q <= set_d;
      err_q <= err_d;
      // A fresh change preempts any calculation in flight, so a stale sum never reaches code.
      if (change_d) begin
        acc_q   <= OFFSET + {4'd0, set_d[3:0]};
        cnt_q   <= set_d[7:4];
        valid_q <= 1'b0;
        state_q <= CALC;
      end else begin
        case (state_q)
          CALC: begin
            if (cnt_q == 4'd0) begin
              code_q  <= acc_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              acc_q <= acc_q + 8'd10;
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sp_if.set_bcd = set_q;
  assign sp_if.code    = code_q;
  assign sp_if.valid   = valid_q;
  assign sp_if.err     = err_q;

endmodule

// File: tb/tb_setpoint_encoder.sv
// Directed bench for setpoint_encoder: an integer-valued latency model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_setpoint_encoder;

  localparam logic [7:0] OFFSET = 8'h38;

  logic clk = 1'b0;
  logic rst = 1'b1;
  setpoint_encoder_if sp_if ();

  setpoint_encoder #(.OFFSET(OFFSET), .DEFAULT_SET(8'h23)) dut (
    .clk   (clk),
    .rst   (rst),
    .sp_if (sp_if)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Model: setpoint as an integer 0..99; after a change the result appears tens+1 edges later.
  int         m_sp    = 23;
  int         m_wait  = 0;
  logic [7:0] m_code  = 8'h4F;
  logic       m_valid = 1'b1;
  logic       m_err   = 1'b0;

  always @(posedge clk or posedge rst) begin
    int nv;
    int lt;
    int lo;
    bit chg;
    if (rst) begin
      m_sp    <= 23;
      m_wait  <= 0;
      m_code  <= 8'((int'(OFFSET) + 23) % 256);
      m_valid <= 1'b1;
      m_err   <= 1'b0;
    end else begin
      lt  = int'(sp_if.load_bcd[7:4]);
      lo  = int'(sp_if.load_bcd[3:0]);
      nv  = m_sp;
      chg = 1'b0;
      m_err <= 1'b0;
      if (sp_if.load) begin
        if (lt < 10 && lo < 10) begin
          nv  = lt * 10 + lo;
          chg = 1'b1;
        end else begin
          m_err <= 1'b1;
        end
      end else if (sp_if.up && !sp_if.down) begin
        if (m_sp < 99) begin nv = m_sp + 1; chg = 1'b1; end
      end else if (sp_if.down && !sp_if.up) begin
        if (m_sp > 0) begin nv = m_sp - 1; chg = 1'b1; end
      end
      if (chg) begin
        m_sp    <= nv;
        m_wait  <= nv / 10 + 1;
        m_valid <= 1'b0;
      end else if (m_wait > 0) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_code  <= 8'((int'(OFFSET) + m_sp) % 256);
          m_valid <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_set_bcd", sp_if.set_bcd, to_bcd(m_sp));
      check("cyc_code",    sp_if.code,    m_code);
      check("cyc_valid",   {7'd0, sp_if.valid}, {7'd0, m_valid});
      check("cyc_err",     {7'd0, sp_if.err},   {7'd0, m_err});
    end
  end

  // Drives one set of pulses so they are sampled on the next rising edge; returns 1ns after it.
  task automatic pulse(bit u, bit d, bit l, logic [7:0] b);
    @(posedge clk); #1;
    sp_if.up = u; sp_if.down = d; sp_if.load = l; sp_if.load_bcd = b;
    @(posedge clk); #1;
    sp_if.up = 1'b0; sp_if.down = 1'b0; sp_if.load = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(int max_cycles);
    for (int i = 0; i < max_cycles && sp_if.valid !== 1'b1; i++) step();
    check("wait_valid", {7'd0, sp_if.valid}, 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sp_if.up = 1'b0; sp_if.down = 1'b0; sp_if.load = 1'b0; sp_if.load_bcd = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    check("rst_set_bcd", sp_if.set_bcd, 8'h23);
    check("rst_code",    sp_if.code,    8'h4F);
    check("rst_valid",   {7'd0, sp_if.valid}, 8'd1);
    check("rst_err",     {7'd0, sp_if.err},   8'd0);

    // Load 99: valid low for edges N..N+9, result at N+10.
    pulse(1'b0, 1'b0, 1'b1, 8'h99);
    for (int i = 0; i < 10; i++) begin
      check("l99_valid_low", {7'd0, sp_if.valid}, 8'd0);
      step();
    end
    check("l99_code",  sp_if.code, 8'h9B);
    check("l99_valid", {7'd0, sp_if.valid}, 8'd1);

    // From 19, up to 20: code 4C three edges later.
    pulse(1'b0, 1'b0, 1'b1, 8'h19);
    wait_valid(12);
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    check("up_set_bcd", sp_if.set_bcd, 8'h20);
    step(); step();
    check("up_valid_low", {7'd0, sp_if.valid}, 8'd0);
    step();
    check("up_code",  sp_if.code, 8'h4C);
    check("up_valid", {7'd0, sp_if.valid}, 8'd1);

    for (int i = 0; i < 99; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      wait_valid(12);
    end
    check("dn_set_bcd", sp_if.set_bcd, 8'h00);
    check("dn_code",    sp_if.code,    8'h38);
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    check("dn_sat_set",   sp_if.set_bcd, 8'h00);
    check("dn_sat_valid", {7'd0, sp_if.valid}, 8'd1);

    // Invalid load: error pulse only.
    pulse(1'b0, 1'b0, 1'b1, 8'h3A);
    check("bad_err",     {7'd0, sp_if.err},   8'd1);
    check("bad_set_bcd", sp_if.set_bcd, 8'h00);
    check("bad_code",    sp_if.code,    8'h38);
    check("bad_valid",   {7'd0, sp_if.valid}, 8'd1);
    step();
    check("bad_err_clr", {7'd0, sp_if.err}, 8'd0);

    // Restart mid-calculation: 90 then 05 two cycles later.
    pulse(1'b0, 1'b0, 1'b1, 8'h90);
    @(posedge clk); #1;
    sp_if.load = 1'b1; sp_if.load_bcd = 8'h05;
    @(posedge clk); #1;
    sp_if.load = 1'b0;
    check("rs_valid_low", {7'd0, sp_if.valid}, 8'd0);
    step();
    check("rs_code",  sp_if.code, 8'h3D);
    check("rs_valid", {7'd0, sp_if.valid}, 8'd1);

    // up+down together: no change.
    pulse(1'b1, 1'b1, 1'b0, 8'h00);
    check("ud_set_bcd", sp_if.set_bcd, 8'h05);
    check("ud_valid",   {7'd0, sp_if.valid}, 8'd1);

    // load beats up.
    pulse(1'b1, 1'b0, 1'b1, 8'h42);
    check("lu_set_bcd", sp_if.set_bcd, 8'h42);
    wait_valid(12);
    check("lu_code", sp_if.code, 8'h62);

    // Reset mid-calculation.
    pulse(1'b0, 1'b0, 1'b1, 8'h77);
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("mr_set_bcd", sp_if.set_bcd, 8'h23);
    check("mr_code",    sp_if.code,    8'h4F);
    check("mr_valid",   {7'd0, sp_if.valid}, 8'd1);
    check("mr_err",     {7'd0, sp_if.err},   8'd0);
    step();
    rst = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    check("post_rst_set", sp_if.set_bcd, 8'h24);
    wait_valid(12);
    check("post_rst_code", sp_if.code, 8'h50);

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
